// File: rtl/ma_clks_group_gen_n.sv
`default_nettype none
// ============================================================================
// ma_clks_group_gen_n : N-channel glitch-free divided clock group with ICG copy.
// Optional group re-align compiled in with `define CLKGRP_ALIGN_EN.  Rev 1.0
// ============================================================================
module ma_clks_group_gen_n #(
    parameter int NCH     = 5,
    parameter int DIV_DW  = 4,
    parameter int RST_DIV = 0
) (
    input  logic                  src_clk_i,
    input  logic                  src_rst_i,
    input  logic [NCH*DIV_DW-1:0] cfg_div_i,
    input  logic [NCH-1:0]        cfg_cken_i,
    input  logic [NCH-1:0]        cfg_icg_on_i,
    input  logic [NCH-1:0]        upd_req_i,
    output logic [NCH-1:0]        upd_ack_o,
    input  logic                  align_req_i,
    output logic                  align_ack_o,
    output logic [NCH-1:0]        clk_out_o,
    output logic [NCH-1:0]        icg_clk_out_o,
    output logic [NCH-1:0]        ch_run_o
);

    localparam int   CW           = DIV_DW + 1;
    localparam logic ICG_TEST_TIE = 1'b0;

`ifdef CLKGRP_ALIGN_EN
    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_PARK = 2'd2
    } state_t;
`else
    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;
`endif

    // High phase length ceil(R/2) with R = code + 2, i.e. (code + 3) >> 1.
    function automatic logic [CW-1:0] high_len(input logic [DIV_DW-1:0] code);
        logic [CW:0] sum;
        sum = {2'b00, code} + (CW+1)'(3);
        return sum[CW:1];
    endfunction

`ifdef CLKGRP_ALIGN_EN
    logic align_pend_q, align_pend_d;
    logic align_ack_q,  align_ack_d;
    logic align_go;

    // Restart fires only once every channel has left RUN, so all resume on one edge.
    assign align_go = align_pend_q & ~(|ch_run_o);

    always_comb begin
        align_ack_d  = align_go;
        align_pend_d = align_pend_q;
        if (align_go) begin
            align_pend_d = 1'b0;
        end else if (align_req_i && !align_ack_q) begin
            align_pend_d = 1'b1;
        end
    end

    always_ff @(posedge src_clk_i or posedge src_rst_i) begin
        if (src_rst_i) begin
            align_pend_q <= 1'b0;
            align_ack_q  <= 1'b0;
        end else begin
            align_pend_q <= align_pend_d;
            align_ack_q  <= align_ack_d;
        end
    end

    assign align_ack_o = align_ack_q;
`else
    logic unused_align;
    assign unused_align = align_req_i;
    assign align_ack_o  = 1'b0;
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        state_t            st_q,  st_d;
        logic [CW-1:0]     cnt_q, cnt_d;
        logic [DIV_DW-1:0] div_q, div_d;
        logic              clk_q, clk_d;
        logic              ack_q, ack_d;
        logic              req;
        logic              period_end;
        logic [DIV_DW-1:0] new_code;
        logic              icg_en_l;

        assign new_code   = cfg_div_i[i*DIV_DW +: DIV_DW];
        assign period_end = (cnt_q == ({1'b0, div_q} + CW'(1)));

`ifdef CLKGRP_ALIGN_EN
        logic hold_q, hold_d;
        // A request is ignored while its ack is in flight or parked awaiting restart.
        assign req = upd_req_i[i] & ~ack_q & ~hold_q;
`else
        assign req = upd_req_i[i] & ~ack_q;
`endif

        always_comb begin
            st_d  = st_q;
            cnt_d = cnt_q;
            div_d = div_q;
            ack_d = 1'b0;
`ifdef CLKGRP_ALIGN_EN
            hold_d = hold_q;
`endif
            case (st_q)
                ST_STOP: begin
                    cnt_d = '0;
                    if (req) begin
                        div_d = new_code;
                        ack_d = 1'b1;
                    end
                    if (cfg_cken_i[i]) begin
                        st_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (period_end) begin
                        cnt_d = '0;
                        if (req) begin
                            div_d = new_code;
                        end
                        ack_d = req;
                        if (!cfg_cken_i[i]) begin
                            st_d = ST_STOP;
                        end
`ifdef CLKGRP_ALIGN_EN
                        // Pending align outranks stop; the update ack waits for restart.
                        if (align_pend_q) begin
                            st_d   = ST_PARK;
                            ack_d  = 1'b0;
                            hold_d = req;
                        end
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
`ifdef CLKGRP_ALIGN_EN
                ST_PARK: begin
                    cnt_d = '0;
                    if (req) begin
                        div_d  = new_code;
                        hold_d = 1'b1;
                    end
                    if (align_go) begin
                        st_d   = cfg_cken_i[i] ? ST_RUN : ST_STOP;
                        ack_d  = hold_q | req;
                        hold_d = 1'b0;
                    end
                end
`endif
                default: begin
                    st_d  = ST_STOP;
                    cnt_d = '0;
                end
            endcase
            clk_d = (st_d == ST_RUN) && (cnt_d < high_len(div_d));
        end

        always_ff @(posedge src_clk_i or posedge src_rst_i) begin
            if (src_rst_i) begin
                st_q  <= ST_STOP;
                cnt_q <= '0;
                div_q <= DIV_DW'(RST_DIV);
                clk_q <= 1'b0;
                ack_q <= 1'b0;
`ifdef CLKGRP_ALIGN_EN
                hold_q <= 1'b0;
`endif
            end else begin
                st_q  <= st_d;
                cnt_q <= cnt_d;
                div_q <= div_d;
                clk_q <= clk_d;
                ack_q <= ack_d;
`ifdef CLKGRP_ALIGN_EN
                hold_q <= hold_d;
`endif
            end
        end

        // Posedge ICG: enable captured only while the divided clock is low.
        always_latch begin
            if (!clk_q) begin
                icg_en_l <= cfg_icg_on_i[i] | ICG_TEST_TIE;
            end
        end

        assign clk_out_o[i]     = clk_q;
        assign icg_clk_out_o[i] = clk_q & icg_en_l;
        assign upd_ack_o[i]     = ack_q;
        assign ch_run_o[i]      = (st_q == ST_RUN);
    end

endmodule
`default_nettype wire

// File: tb/tb_ma_clks_group_gen_n.sv
`default_nettype none
// Directed self-checking bench for ma_clks_group_gen_n (default parameters).
module tb_ma_clks_group_gen_n;

    localparam int NCH    = 5;
    localparam int DIV_DW = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NCH*DIV_DW-1:0] cfg_div;
    logic [NCH-1:0]        cfg_cken;
    logic [NCH-1:0]        cfg_icg_on;
    logic [NCH-1:0]        upd_req;
    logic [NCH-1:0]        upd_ack;
    logic                  align_req;
    logic                  align_ack;
    logic [NCH-1:0]        clk_out;
    logic [NCH-1:0]        icg_clk_out;
    logic [NCH-1:0]        ch_run;

    int checks = 0;
    int errors = 0;

    ma_clks_group_gen_n #(.NCH(NCH), .DIV_DW(DIV_DW), .RST_DIV(0)) dut (
        .src_clk_i     (clk),
        .src_rst_i     (rst),
        .cfg_div_i     (cfg_div),
        .cfg_cken_i    (cfg_cken),
        .cfg_icg_on_i  (cfg_icg_on),
        .upd_req_i     (upd_req),
        .upd_ack_o     (upd_ack),
        .align_req_i   (align_req),
        .align_ack_o   (align_ack),
        .clk_out_o     (clk_out),
        .icg_clk_out_o (icg_clk_out),
        .ch_run_o      (ch_run)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic stop_all();
        cfg_cken = '0;
        repeat (20) @(negedge clk);
    endtask

    task automatic set_div(input int ch, input logic [DIV_DW-1:0] code);
        bit seen = 1'b0;
        @(negedge clk);
        cfg_div[ch*DIV_DW +: DIV_DW] = code;
        upd_req[ch] = 1'b1;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (upd_ack[ch]) seen = 1'b1;
        end
        upd_req[ch] = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL set_div_ack ch%0d: ack=0, required 1 within 40 cycles", ch);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (clk_out !== 5'b0)     begin errors++; $display("FAIL rst_clk_out: got %b, expected 00000", clk_out); end
        checks++; if (icg_clk_out !== 5'b0) begin errors++; $display("FAIL rst_icg: got %b, expected 00000", icg_clk_out); end
        checks++; if (upd_ack !== 5'b0)     begin errors++; $display("FAIL rst_upd_ack: got %b, expected 00000", upd_ack); end
        checks++; if (align_ack !== 1'b0)   begin errors++; $display("FAIL rst_align_ack: got %b, expected 0", align_ack); end
        checks++; if (ch_run !== 5'b0)      begin errors++; $display("FAIL rst_ch_run: got %b, expected 00000", ch_run); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (clk_out !== 5'b0) begin errors++; $display("FAIL post_rst_idle: got %b, expected 00000", clk_out); end
    endtask

    task automatic test_div2();
        logic [NCH-1:0] exp_v;
        cfg_cken   = 5'b11111;
        cfg_icg_on = 5'b11111;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            exp_v = (k % 2 == 0) ? 5'b11111 : 5'b00000;
            checks++;
            if (clk_out !== exp_v) begin errors++; $display("FAIL div2_clk k=%0d: got %b, expected %b", k, clk_out, exp_v); end
            checks++;
            if (icg_clk_out !== exp_v) begin errors++; $display("FAIL div2_icg k=%0d: got %b, expected %b", k, icg_clk_out, exp_v); end
            if (k == 0) begin
                checks++;
                if (ch_run !== 5'b11111) begin errors++; $display("FAIL div2_run: got %b, expected 11111", ch_run); end
            end
        end
    endtask

    task automatic test_ratio_update();
        bit exp_a   [7]  = '{1, 1, 0, 1, 1, 0, 1};
        bit exp_clk [11] = '{1, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1};
        bit exp_ack [11] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        stop_all();
        set_div(0, 4'd1);
        cfg_cken = 5'b00001;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            checks++;
            if (clk_out[0] !== exp_a[k]) begin errors++; $display("FAIL r3_clk k=%0d: got %b, expected %b", k, clk_out[0], exp_a[k]); end
        end
        cfg_div[3:0] = 4'd6;
        upd_req[0]   = 1'b1;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            checks++;
            if (clk_out[0] !== exp_clk[k]) begin errors++; $display("FAIL r8_clk k=%0d: got %b, expected %b", k, clk_out[0], exp_clk[k]); end
            checks++;
            if (upd_ack[0] !== exp_ack[k]) begin errors++; $display("FAIL r8_ack k=%0d: got %b, expected %b", k, upd_ack[0], exp_ack[k]); end
            if (upd_ack[0]) upd_req[0] = 1'b0;
        end
        upd_req[0] = 1'b0;
    endtask

    task automatic test_cken_drop();
        bit exp_clk [9] = '{1, 1, 1, 0, 0, 0, 0, 0, 0};
        bit exp_run [9] = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
        stop_all();
        set_div(2, 4'd4);
        cfg_cken = 5'b00100;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            checks++;
            if (clk_out[2] !== exp_clk[k]) begin errors++; $display("FAIL cken_drop_clk k=%0d: got %b, expected %b", k, clk_out[2], exp_clk[k]); end
            checks++;
            if (ch_run[2] !== exp_run[k]) begin errors++; $display("FAIL cken_drop_run k=%0d: got %b, expected %b", k, ch_run[2], exp_run[k]); end
            if (k == 1) cfg_cken[2] = 1'b0;
        end
    endtask

    task automatic test_align();
        int ack_cnt = 0;
`ifdef CLKGRP_ALIGN_EN
        int       ack_at    = -1;
        logic [2:0] prev    = 3'b000;
        logic [2:0] prev_at = 3'b111;
        logic [2:0] clk_at  = 3'b000;
        logic [2:0] run_at  = 3'b000;
        logic [2:0] clk_aft = 3'b000;
`endif
        stop_all();
        set_div(0, 4'd0);
        set_div(1, 4'd3);
        set_div(2, 4'd7);
        cfg_cken[0] = 1'b1;
        @(negedge clk);
        cfg_cken[1] = 1'b1;
        repeat (2) @(negedge clk);
        cfg_cken[2] = 1'b1;
        repeat (3) @(negedge clk);
        align_req = 1'b1;
`ifdef CLKGRP_ALIGN_EN
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (ack_at >= 0 && k == ack_at + 1) clk_aft = clk_out[2:0];
            if (align_ack) begin
                ack_cnt++;
                if (ack_at < 0) begin
                    ack_at    = k;
                    clk_at    = clk_out[2:0];
                    run_at    = ch_run[2:0];
                    prev_at   = prev;
                    align_req = 1'b0;
                end
            end
            prev = clk_out[2:0];
        end
        align_req = 1'b0;
        checks++; if (ack_cnt !== 1) begin errors++; $display("FAIL align_ack_count: got %0d, expected 1", ack_cnt); end
        checks++; if (ack_at < 1 || ack_at > 11) begin errors++; $display("FAIL align_latency: got %0d cycles, expected 1..11", ack_at); end
        checks++; if (clk_at !== 3'b111) begin errors++; $display("FAIL align_common_rise: got %b, expected 111", clk_at); end
        checks++; if (prev_at !== 3'b000) begin errors++; $display("FAIL align_parked_low: got %b, expected 000", prev_at); end
        checks++; if (run_at !== 3'b111) begin errors++; $display("FAIL align_run: got %b, expected 111", run_at); end
        checks++; if (clk_aft !== 3'b110) begin errors++; $display("FAIL align_after: got %b, expected 110", clk_aft); end
`else
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (align_ack) ack_cnt++;
        end
        align_req = 1'b0;
        checks++; if (ack_cnt !== 0) begin errors++; $display("FAIL align_ack_tied: got %0d pulses, expected 0", ack_cnt); end
        checks++; if (ch_run[2:0] !== 3'b111) begin errors++; $display("FAIL align_ignored_run: got %b, expected 111", ch_run[2:0]); end
`endif
    endtask

    task automatic test_reset_pending();
        bit   hi = 1'b0;
        int   ack_seen = 0;
        logic [2:0] exp_v;
        for (int k = 0; k < 4 && !hi; k++) begin
            @(negedge clk);
            hi = clk_out[0];
        end
        checks++; if (!hi) begin errors++; $display("FAIL rstp_pre_high: got 0, expected clk_out[0]=1"); end
        cfg_div[7:4] = 4'd9;
        upd_req[1]   = 1'b1;
        #2 rst = 1'b1;
        #1;
        checks++; if (clk_out !== 5'b0)     begin errors++; $display("FAIL rstp_clk: got %b, expected 00000", clk_out); end
        checks++; if (icg_clk_out !== 5'b0) begin errors++; $display("FAIL rstp_icg: got %b, expected 00000", icg_clk_out); end
        checks++; if (ch_run !== 5'b0)      begin errors++; $display("FAIL rstp_run: got %b, expected 00000", ch_run); end
        checks++; if (upd_ack !== 5'b0)     begin errors++; $display("FAIL rstp_ack: got %b, expected 00000", upd_ack); end
        @(negedge clk);
        upd_req[1] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (upd_ack !== 5'b0) ack_seen++;
            if (k < 4) begin
                exp_v = (k % 2 == 0) ? 3'b111 : 3'b000;
                checks++;
                if (clk_out[2:0] !== exp_v) begin errors++; $display("FAIL rstp_div2 k=%0d: got %b, expected %b", k, clk_out[2:0], exp_v); end
            end
        end
        checks++; if (ack_seen !== 0) begin errors++; $display("FAIL rstp_no_ack: got %0d ack cycles, expected 0", ack_seen); end
    endtask

    task automatic test_icg_toggle();
        bit exp_clk [12] = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0};
        bit exp_icg [12] = '{1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0};
        stop_all();
        cfg_icg_on = 5'b11111;
        set_div(3, 4'd2);
        cfg_cken = 5'b01000;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checks++;
            if (clk_out[3] !== exp_clk[k]) begin errors++; $display("FAIL icg_clk k=%0d: got %b, expected %b", k, clk_out[3], exp_clk[k]); end
            checks++;
            if (icg_clk_out[3] !== exp_icg[k]) begin errors++; $display("FAIL icg_out k=%0d: got %b, expected %b", k, icg_clk_out[3], exp_icg[k]); end
            if (k == 0) begin
                cfg_icg_on[3] = 1'b0;
                #1;
                checks++;
                if (icg_clk_out[3] !== 1'b1) begin errors++; $display("FAIL icg_no_trunc: got %b, expected 1", icg_clk_out[3]); end
            end
            if (k == 5) begin
                cfg_icg_on[3] = 1'b1;
                #1;
                checks++;
                if (icg_clk_out[3] !== 1'b0) begin errors++; $display("FAIL icg_no_runt: got %b, expected 0", icg_clk_out[3]); end
            end
        end
    endtask

    initial begin
        cfg_div    = '0;
        cfg_cken   = '0;
        cfg_icg_on = '0;
        upd_req    = '0;
        align_req  = 1'b0;
        test_reset();
        test_div2();
        test_ratio_update();
        test_cken_drop();
        test_align();
        test_reset_pending();
        test_icg_toggle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
